// File: rtl/serial_add_ctrl.sv
// -----------------------------------------------------------------------------
// serial_add_ctrl
//   Bit-serial adder controller. One full-adder slice is reused over WIDTH
//   clock cycles to add two WIDTH-bit operands LSB first, with the carry held
//   in a flip-flop between bit steps. Costs WIDTH+2 cycles per operation in
//   exchange for a single adder cell.
//
//   Handshake: start is sampled only while idle. busy is high for the WIDTH
//   bit-step cycles, then done pulses for one cycle. sum/cout/overflow are
//   loaded on the final bit step and hold until the next operation completes
//   or until reset.
//
// Ports
//   clk       in   1      rising-edge clock
//   rst       in   1      synchronous active-high reset
//   start     in   1      operation request (ignored unless idle)
//   a, b      in   WIDTH  operands, captured on an accepted start
//   cin       in   1      carry-in, captured on an accepted start
//   busy      out  1      high while bit steps are in progress
//   done      out  1      one-cycle pulse, result valid
//   sum       out  WIDTH  registered result
//   cout      out  1      carry out of the MSB
//   overflow  out  1      signed overflow (carry into MSB xor carry out)
// -----------------------------------------------------------------------------
module serial_add_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             overflow
);

    localparam int CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0]   a_sh_q, a_sh_d;
    logic [WIDTH-1:0]   b_sh_q, b_sh_d;
    logic               c_q, c_d;
    logic [WIDTH-1:0]   psum_q, psum_d;
    logic [WIDTH-1:0]   sum_q, sum_d;
    logic               cout_q, cout_d;
    logic               ovf_q, ovf_d;
    logic [1:0]         fa;

    // The single shared slice: returns {carry_out, sum_bit}.
    function automatic logic [1:0] full_adder(input logic x, input logic y, input logic c);
        full_adder = {(x & y) | (c & (x ^ y)), x ^ y ^ c};
    endfunction

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = RUN;
            RUN:     if (cnt_q == LAST) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Bit-step datapath
    always_comb begin
        fa     = full_adder(a_sh_q[0], b_sh_q[0], c_q);
        a_sh_d = a_sh_q;
        b_sh_d = b_sh_q;
        c_d    = c_q;
        cnt_d  = cnt_q;
        psum_d = psum_q;
        sum_d  = sum_q;
        cout_d = cout_q;
        ovf_d  = ovf_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    a_sh_d = a;
                    b_sh_d = b;
                    c_d    = cin;
                    cnt_d  = '0;
                    psum_d = '0;
                end
            end
            RUN: begin
                // Sum bits enter at the MSB end so that after WIDTH steps
                // bit 0 of the result has reached position 0.
                psum_d = {fa[0], psum_q[WIDTH-1:1]};
                a_sh_d = a_sh_q >> 1;
                b_sh_d = b_sh_q >> 1;
                c_d    = fa[1];
                if (cnt_q == LAST) begin
                    sum_d  = psum_d;
                    cout_d = fa[1];
                    // c_q is the carry into the MSB on this final step.
                    ovf_d  = c_q ^ fa[1];
                end else begin
                    // Counter stops at LAST so it never wraps.
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q  <= '0;
            a_sh_q <= '0;
            b_sh_q <= '0;
            c_q    <= 1'b0;
            psum_q <= '0;
            sum_q  <= '0;
            cout_q <= 1'b0;
            ovf_q  <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            a_sh_q <= a_sh_d;
            b_sh_q <= b_sh_d;
            c_q    <= c_d;
            psum_q <= psum_d;
            sum_q  <= sum_d;
            cout_q <= cout_d;
            ovf_q  <= ovf_d;
        end
    end

    // Output logic
    always_comb begin
        busy     = (state_q == RUN);
        done     = (state_q == DONE);
        sum      = sum_q;
        cout     = cout_q;
        overflow = ovf_q;
    end

endmodule
